lht_ctrl: RTL
=============

# lht_ctrl

Controller for the 256×8 local history table SRAM (`lht_sram`, 1W/1R, registered address/data inputs). It clears the table after reset, then arbitrates the single read port between predictor lookups and commit-time history updates. Each update is a read-modify-write that shifts the resolved direction into the entry's history. A one-entry write-forwarding register hides the SRAM's write-visibility latency, so every lookup and every update read returns the most recently written value.

## Interface
- ADDR_WIDTH, 8, table index width; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 8, history bits per entry (DATA_WIDTH ≥ 2)

- clk  in  1  single clock; drives both SRAM ports
- rst  in  1  synchronous, active-high reset
- lookup_valid  in  1  predictor read request
- lookup_idx  in  ADDR_WIDTH  entry to read
- lookup_ready  out  1  lookup accepted at an edge where valid && ready
- resp_valid  out  1  lookup result valid this cycle
- resp_hist  out  DATA_WIDTH  lookup result
- upd_valid  in  1  commit update request
- upd_idx  in  ADDR_WIDTH  entry to update
- upd_taken  in  1  resolved direction shifted into the entry
- upd_ready  out  1  update accepted at an edge where valid && ready
- init_done  out  1  clear sweep complete
- sram_csb0  out  1  write-port chip select, active low
- sram_addr0  out  ADDR_WIDTH  write address
- sram_din0  out  DATA_WIDTH  write data
- sram_csb1  out  1  read-port chip select, active low
- sram_addr1  out  ADDR_WIDTH  read address
- sram_dout1  in  DATA_WIDTH  read data; combinational from the registered read address

## Operation
- States:
  - RESET: rst high.
  - INIT: clear sweep.
  - RUN: normal operation.
  - rst high in any state forces INIT on the next cycle and restarts the sweep from index 0.
- INIT:
  - Counter `cnt` runs 0 to 2^ADDR_WIDTH−1, one write per cycle: csb0=0, addr0=cnt, din0=0.
  - csb1=1, lookup_ready=0, upd_ready=0.
  - After the write with cnt = max issues, the FSM moves to RUN.
- RUN:
  - upd_ready=1 and init_done=1.
  - lookup_ready = !upd_valid. Updates have fixed priority on the read port, so sustained updates may starve lookups.
- Read port mux:
  - Update accepted: csb1=0, addr1=upd_idx.
  - Else lookup accepted: csb1=0, addr1=lookup_idx.
  - Else csb1=1.
- Update pipeline, stage U1 (register idx and taken):
  - In the cycle after acceptance, old = fwd(sram_dout1).
  - new = {old[DATA_WIDTH−2:0], taken}; the MSB is discarded.
  - U2: csb0=0, addr0=idx, din0=new are issued at the next edge.
  - One update may be accepted every cycle; U1 and U2 overlap.
- Forwarding register:
  - Holds {fv, fidx, fdata} and loads on every write issued, both INIT and U2.
  - It is valid for exactly the cycle after the write issue, the only cycle in which the SRAM still returns stale data for a read issued at that same edge.
  - fwd(x) = (fv && fidx == read address registered at that edge) ? fdata : x.
- Lookup response: resp_valid is registered as (lookup accepted); resp_hist = fwd(sram_dout1) during that cycle.
- Reset values:
  - resp_valid=0, lookup_ready=0, upd_ready=0, init_done=0.
  - csb0=1, csb1=1, fv=0.
  - U1 is dropped and cnt=0.
- Reset mid-sweep or mid-update: in-flight update and response are discarded without a write; the full sweep reruns.

## Timing
- INIT is 2^ADDR_WIDTH cycles. lookup_ready first rises exactly 256 cycles after the first cycle with rst low (default params).
- Lookup latency is 1: accepted at edge N, resp_valid and resp_hist are valid in cycle N..N+1.
- Update, accepted at edge A:
  - SRAM read issued at A.
  - Write issued at A+1.
  - Memory updated at A+2.
  - Any read issued at A+1 or later observes the new value: via forwarding at A+1, via the array from A+2.
- Lookups accepted before an update's edge A return the pre-update value. Ordering is by acceptance edge.
- Back-to-back updates to the same index at A and A+1: the second RMW reads the first result via forwarding.

## Test plan
- Init: hold rst for 3 cycles, then release. Expect 256 consecutive writes, addr 0..255, din 0x00. lookup_ready=1 at cycle 256. A lookup of idx 0x5A returns 0x00.
- Single updates: idx 0x10 with taken 1,1,1, spaced 4 cycles apart. A lookup of 0x10 then returns 0x07. Idx 0x11 is unaffected and returns 0x00.
- Back-to-back same-index updates: idx 0x20 with taken 1,0,1,1 on consecutive cycles. A lookup in the cycle after the last acceptance returns 0x0B via forwarding. A lookup 5 cycles later also returns 0x0B.
- Conflict: upd_valid and lookup_valid in the same cycle, both idx 0x30, taken=1, entry initially 0x00. Expect lookup_ready=0 and the update accepted. The lookup is accepted at the next edge and its response is 0x01.
- Lookup throughput: lookups of idx 1, 2, 3 on consecutive cycles after updates set 0x01, 0x00, 0x01. Expect resp_valid on 3 consecutive cycles with values 0x01, 0x00, 0x01.
- Reset mid-operation:
  - Assert rst at sweep cycle 100. The sweep restarts at addr 0.
  - Assert rst while U1 is holding idx 0x40. No write to 0x40 occurs, and after re-init entry 0x40 reads 0x00.

Source files
------------

// File: rtl/lht_ctrl.sv
// Controller for the local history table SRAM: clears the table after reset, then
// arbitrates the read port between lookups and read-modify-write history updates.
module lht_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [ADDR_WIDTH-1:0] lookup_idx,
  output logic                  lookup_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_hist,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  upd_ready,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  u1_valid;
  logic [ADDR_WIDTH-1:0] u1_idx;
  logic                  u1_taken;
  logic                  fv;
  logic [ADDR_WIDTH-1:0] fidx;
  logic [DATA_WIDTH-1:0] fdata;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] upd_hist;
  logic                  upd_acc;
  logic                  lookup_acc;
  logic                  init_wr;
  logic                  upd_wr;

  // rst gates every port strobe so nothing reaches the SRAM at a reset edge
  assign upd_ready    = (state == ST_RUN) && !rst;
  assign lookup_ready = upd_ready && !upd_valid;
  assign upd_acc      = upd_valid && upd_ready;
  assign lookup_acc   = lookup_valid && lookup_ready;
  assign init_wr      = (state == ST_INIT) && !rst;
  assign upd_wr       = u1_valid && !rst;
  assign init_done    = (state == ST_RUN);

  // The SRAM returns stale data for a read registered at the same edge as a write
  assign rd_data  = (fv && (fidx == rd_addr)) ? fdata : sram_dout1;
  assign upd_hist = {rd_data[DATA_WIDTH-2:0], u1_taken};
  assign resp_hist = rd_data;

  assign sram_csb0  = !(init_wr || upd_wr);
  assign sram_addr0 = init_wr ? cnt : u1_idx;
  assign sram_din0  = init_wr ? '0 : upd_hist;
  assign sram_csb1  = !(upd_acc || lookup_acc);
  assign sram_addr1 = upd_acc ? upd_idx : lookup_idx;

  always_ff @(posedge clk) begin
    if (upd_acc) begin
      u1_idx   <= upd_idx;
      u1_taken <= upd_taken;
    end
    if (!sram_csb0) begin
      fidx  <= sram_addr0;
      fdata <= sram_din0;
    end
    if (!sram_csb1) rd_addr <= sram_addr1;

    if (rst) begin
      state      <= ST_INIT;
      cnt        <= '0;
      u1_valid   <= 1'b0;
      resp_valid <= 1'b0;
      fv         <= 1'b0;
    end else begin
      if (state == ST_INIT) begin
        cnt <= cnt + ADDR_WIDTH'(1);
        if (cnt == '1) state <= ST_RUN;
      end
      u1_valid   <= upd_acc;
      resp_valid <= lookup_acc;
      fv         <= !sram_csb0;
    end
  end

endmodule
